fop_core: RTL and testbench

//  Minimal accumulator processor ("fop"). Executes a fixed 16-entry program ROM.

---
 rtl/fop_pkg.sv | 56 +++++
 rtl/fop_if.sv | 28 ++
 rtl/fop_rom.sv | 16 +
 rtl/fop_core.sv | 103 ++++++++++
 tb/tb_fop_core.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fop_pkg.sv
// fop_pkg: shared types and constants for the fop accumulator processor.
//   - DATA_W / PC_W : accumulator and program-counter widths
//   - opcode_e      : 4-bit opcode encoding (A-E are undefined and run as NOP)
//   - state_e       : FSM states FETCH / EXEC / HALT
//   - instr_t       : 8-bit instruction {op, imm}
//   - program_t     : a full 16-entry program image
//   - PROGRAM       : the default program executed by fop_core
package fop_pkg;

    localparam int DATA_W    = 8;
    localparam int PC_W      = 4;
    localparam int ROM_DEPTH = 1 << PC_W;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_ADDI = 4'h2,
        OP_SUBI = 4'h3,
        OP_ANDI = 4'h4,
        OP_ORI  = 4'h5,
        OP_XORI = 4'h6,
        OP_JMP  = 4'h7,
        OP_JZ   = 4'h8,
        OP_OUT  = 4'h9,
        OP_HLT  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        HALT
    } state_e;

    typedef struct packed {
        opcode_e    op;
        logic [3:0] imm;
    } instr_t;

    typedef instr_t [ROM_DEPTH-1:0] program_t;

    // Counts acc down from 2, emitting it on each pass, and halts once it hits zero.
    function automatic program_t default_program();
        program_t p;
        p    = '0;
        p[0] = '{op: OP_LDI,  imm: 4'd2};
        p[1] = '{op: OP_OUT,  imm: 4'd0};
        p[2] = '{op: OP_SUBI, imm: 4'd1};
        p[3] = '{op: OP_JZ,   imm: 4'd5};
        p[4] = '{op: OP_JMP,  imm: 4'd1};
        p[5] = '{op: OP_HLT,  imm: 4'd0};
        return p;
    endfunction

    localparam program_t PROGRAM = default_program();

endpackage

// File: rtl/fop_if.sv
// fop_if: enable input and observation outputs of fop_core.
//   enable    : 1 = advance the core, 0 = hold all state
//   pc_o      : current program counter
//   acc_o     : current accumulator
//   out_data  : value written by the last OUT instruction
//   out_valid : one-cycle pulse when out_data is updated
//   halted    : 1 once HLT has executed, until reset
// modport master drives enable and observes; modport slave is the core side.
interface fop_if;

    logic                        enable;
    logic [fop_pkg::PC_W-1:0]    pc_o;
    logic [fop_pkg::DATA_W-1:0]  acc_o;
    logic [fop_pkg::DATA_W-1:0]  out_data;
    logic                        out_valid;
    logic                        halted;

    modport master (
        output enable,
        input  pc_o, acc_o, out_data, out_valid, halted
    );

    modport slave (
        input  enable,
        output pc_o, acc_o, out_data, out_valid, halted
    );

endinterface

// File: rtl/fop_rom.sv
// fop_rom: combinational 16x8 program lookup.
//   PROG   : program image (defaults to fop_pkg::PROGRAM)
//   addr_i : word index (the program counter)
//   data_o : instruction stored at addr_i
module fop_rom
    import fop_pkg::*;
#(
    parameter program_t PROG = PROGRAM
) (
    input  logic [PC_W-1:0] addr_i,
    output instr_t          data_o
);

    assign data_o = PROG[addr_i];

endmodule

// File: rtl/fop_core.sv
// fop_core: minimal accumulator processor. Each instruction takes two enabled
// cycles (FETCH then EXEC); HLT parks the FSM in HALT until reset.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low (0 = in reset)
//   bus   : fop_if.slave -- enable in; pc_o, acc_o, out_data, out_valid,
//           halted out (all driven straight from registers)
//   PROG  : program image, overridable to run alternative programs
module fop_core
    import fop_pkg::*;
#(
    parameter program_t PROG = PROGRAM
) (
    input  logic clk,
    input  logic reset,
    fop_if.slave bus
);

    state_e              state_q;
    logic [PC_W-1:0]     pc_q;
    logic [PC_W-1:0]     pc_d;
    logic [DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]   acc_d;
    logic [DATA_W-1:0]   imm_ext;
    instr_t              ir_q;
    instr_t              rom_data;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_valid_q;
    logic                halted_q;

    fop_rom #(.PROG(PROG)) u_rom (
        .addr_i (pc_q),
        .data_o (rom_data)
    );

    // Execute-stage datapath: the accumulator and pc values an EXEC edge commits.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        imm_ext = DATA_W'(ir_q.imm);
        acc_d   = acc_q;
        pc_d    = pc_q + 1'b1;
        case (ir_q.op)
            OP_LDI:  acc_d = imm_ext;
            OP_ADDI: acc_d = acc_q + imm_ext;
            OP_SUBI: acc_d = acc_q - imm_ext;
            OP_ANDI: acc_d = acc_q & imm_ext;
            OP_ORI:  acc_d = acc_q | imm_ext;
            OP_XORI: acc_d = acc_q ^ imm_ext;
            OP_JMP:  pc_d  = ir_q.imm;
            OP_JZ:   if (acc_q == '0) pc_d = ir_q.imm;
            OP_HLT:  pc_d  = pc_q;          // pc stays on the HLT word
            default: ;                      // NOP, OUT and undefined opcodes
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH;
            pc_q        <= '0;
            acc_q       <= '0;
            ir_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; blocking here would create ordering races.
            // out_valid only survives one edge; held cycles also force it low.
            out_valid_q <= 1'b0;
            if (bus.enable) begin
                case (state_q)
                    FETCH: begin
                        ir_q    <= rom_data;
                        state_q <= EXEC;
                    end
                    EXEC: begin
                        acc_q <= acc_d;
                        pc_q  <= pc_d;
                        if (ir_q.op == OP_OUT) begin
                            out_data_q  <= acc_q;
                            out_valid_q <= 1'b1;
                        end
                        if (ir_q.op == OP_HLT) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                    HALT:    state_q <= HALT;
                    default: state_q <= FETCH;
                endcase
            end
        end
    end

    assign bus.pc_o      = pc_q;
    assign bus.acc_o     = acc_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_fop_core.sv
// tb_fop_core: drives two fop_core instances (default program, and a
// wrap-around ADDI program with an undefined opcode) against an
// instruction-level reference model.
module tb_fop_core;
    import fop_pkg::*;

    // 15 x ADDI 15, then opcode 0xB (undefined, runs as NOP) at word 15.
    localparam program_t TEST_PROG = program_t'({8'hB3, {15{8'h2F}}});

    logic clk;
    logic reset;

    fop_if if_a ();
    fop_if if_b ();

    fop_core dut_a (.clk(clk), .reset(reset), .bus(if_a));
    fop_core #(.PROG(TEST_PROG)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int   pc;
        int   acc;
        bit   mid;        // fetched, waiting to execute
        bit   halted;
        byte  instr;
        int   out_data;
        bit   out_valid;
    } model_t;

    logic [7:0] rom_a [16];
    logic [7:0] rom_b [16];
    model_t ma, mb;

    function automatic model_t model_reset();
        model_t m;
        m.pc = 0; m.acc = 0; m.mid = 0; m.halted = 0;
        m.instr = 0; m.out_data = 0; m.out_valid = 0;
        return m;
    endfunction

    function automatic model_t model_step(model_t s, logic [7:0] rom [16], bit en);
        model_t n;
        int op, imm;
        n = s;
        n.out_valid = 0;
        if (!en || s.halted) return n;
        if (!s.mid) begin
            n.instr = rom[s.pc];
            n.mid   = 1;
            return n;
        end
        n.mid = 0;
        op  = (int'(s.instr) >> 4) & 15;
        imm = int'(s.instr) & 15;
        n.pc = (s.pc + 1) % 16;
        case (op)
            1:  n.acc = imm;
            2:  n.acc = (s.acc + imm) % 256;
            3:  n.acc = (s.acc - imm + 256) % 256;
            4:  n.acc = s.acc & imm;
            5:  n.acc = s.acc | imm;
            6:  n.acc = s.acc ^ imm;
            7:  n.pc  = imm;
            8:  if (s.acc == 0) n.pc = imm;
            9:  begin n.out_data = s.acc; n.out_valid = 1; end
            15: begin n.halted = 1; n.pc = s.pc; end
            default: ;
        endcase
        return n;
    endfunction

    task automatic compare_all();
        check("a_pc",        if_a.pc_o,      ma.pc);
        check("a_acc",       if_a.acc_o,     ma.acc);
        check("a_out_data",  if_a.out_data,  ma.out_data);
        check("a_out_valid", if_a.out_valid, ma.out_valid);
        check("a_halted",    if_a.halted,    ma.halted);
        check("b_pc",        if_b.pc_o,      mb.pc);
        check("b_acc",       if_b.acc_o,     mb.acc);
        check("b_out_valid", if_b.out_valid, mb.out_valid);
        check("b_halted",    if_b.halted,    mb.halted);
    endtask

    // Called at a negedge: drive enables, take one rising edge, compare at the next negedge.
    task automatic cycle(input bit en_a, input bit en_b);
        if_a.enable = en_a;
        if_b.enable = en_b;
        @(posedge clk);
        if (reset) begin
            ma = model_step(ma, rom_a, en_a);
            mb = model_step(mb, rom_b, en_b);
        end
        @(negedge clk);
        compare_all();
    endtask

    // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
    task automatic pulse_reset(input int hold_cycles);
        #2;
        reset = 1'b0;
        ma = model_reset();
        mb = model_reset();
        #1;
        compare_all();
        for (int i = 0; i < hold_cycles; i++) cycle(1, 1);
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            rom_a[i] = 8'h00;
            rom_b[i] = 8'h2F;
        end
        rom_a[0] = 8'h12; rom_a[1] = 8'h90; rom_a[2] = 8'h31;
        rom_a[3] = 8'h85; rom_a[4] = 8'h71; rom_a[5] = 8'hF0;
        rom_b[15] = 8'hB3;

        // Scenario 1: reset held low for 2 cycles with enable high.
        reset = 1'b0;
        if_a.enable = 1'b1;
        if_b.enable = 1'b1;
        ma = model_reset();
        mb = model_reset();
        @(negedge clk);
        compare_all();
        cycle(1, 1);
        cycle(1, 1);
        reset = 1'b1;

        // Scenarios 2/3 and the wrap program, with fixed expected milestones.
        for (int e = 1; e <= 40; e++) begin
            cycle(1, 1);
            if (e == 2)  check("s2_acc", if_a.acc_o, 2);
            if (e == 4) begin
                check("s2_out_valid", if_a.out_valid, 1);
                check("s2_out_data",  if_a.out_data,  2);
            end
            if (e == 5)  check("s2_out_pulse_end", if_a.out_valid, 0);
            if (e == 12) begin
                check("s3_out_valid", if_a.out_valid, 1);
                check("s3_out_data",  if_a.out_data,  1);
            end
            if (e >= 18) begin
                check("s3_halted", if_a.halted, 1);
                check("s3_pc",     if_a.pc_o,   5);
                check("s3_acc",    if_a.acc_o,  0);
            end
            if (e == 32) check("s6_pc_wrap", if_b.pc_o, 0);
            if (e == 36) check("s6_acc_255", if_b.acc_o, 255);
            if (e == 38) check("s6_acc_14",  if_b.acc_o, 14);
        end

        // Scenario 5 from the halted state: reset restarts at pc 0.
        pulse_reset(1);
        for (int e = 1; e <= 5; e++) cycle(1, 1);
        // Scenario 4: enable low for 5 cycles after edge 5.
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0);
            check("s4_pc_frozen",  if_a.pc_o,      2);
            check("s4_acc_frozen", if_a.acc_o,     2);
            check("s4_no_pulse",   if_a.out_valid, 0);
        end
        for (int e = 6; e <= 18; e++) begin
            cycle(1, 1);
            if (e == 12) check("s4_resume_out", if_a.out_data, 1);
        end
        check("s4_resume_halt", if_a.halted, 1);

        // Scenario 5 mid-loop: reset at edge 9, then the sequence repeats.
        pulse_reset(1);
        for (int e = 1; e <= 9; e++) cycle(1, 1);
        pulse_reset(2);
        for (int e = 1; e <= 4; e++) cycle(1, 1);
        check("s5_out_data", if_a.out_data, 2);

        // Randomized enables and occasional asynchronous resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 59) == 0) pulse_reset($urandom_range(0, 2));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
